// File: rtl/grid_io_cfg_array.sv
// Perimeter I/O tile: NUM_PADS GPIO pads configured by a serial ccff chain with a
// shadow shift register, an active config loaded by explicit commit, and a sticky error flag.
module grid_io_cfg_array #(
  parameter int NUM_PADS    = 8,
  parameter int CFG_PER_PAD = 4,
  parameter int CHAIN_LEN   = NUM_PADS * CFG_PER_PAD
) (
  input  logic                prog_clk,
  input  logic                pReset,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_PADS-1:0] outpad,
  output logic [NUM_PADS-1:0] inpad,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_commit,
  output logic                ccff_tail,
  output logic                cfg_loaded,
  output logic                cfg_err,
  output logic                dbg_state
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CHAIN_LEN);

  typedef enum logic {
    ST_SHIFT  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  // Handshake: no valid/ready pair here; ccff_en qualifies ccff_head on each rising
  // prog_clk edge, and ccff_commit is sampled as a single-cycle request on the same edge.

  state_t                 state_q, state_d;
  logic [CHAIN_LEN-1:0]   sr_q, sr_d;
  logic [CHAIN_LEN-1:0]   act_q, act_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= ST_SHIFT;
      sr_q    <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (ccff_en) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_SHIFT: begin
        if (ccff_commit) err_d = 1'b1;
        if (cnt_d == CNT_MAX) state_d = ST_LOADED;
      end
      ST_LOADED: begin
        // Commit takes the pre-shift chain; a same-cycle shift counts toward the next load.
        if (ccff_commit) begin
          act_d   = sr_q;
          cnt_d   = ccff_en ? CW'(1) : '0;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  assign ccff_tail  = sr_q[CHAIN_LEN-1];
  assign cfg_loaded = (cnt_q == CNT_MAX);
  assign cfg_err    = err_q;
  assign dbg_state  = state_q;

  // Mode word per pad: bit0 oe, bit1 out_inv, bit2 in_inv, bit3 in_en.
  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    assign gfpga_pad_GPIO_PAD[k] = act_q[4*k] ? (outpad[k] ^ act_q[4*k+1]) : 1'bz;
    assign inpad[k] = act_q[4*k+3] ? (gfpga_pad_GPIO_PAD[k] ^ act_q[4*k+2]) : 1'b0;
  end

endmodule

// File: tb/tb_grid_io_cfg_array.sv
// Directed bench for grid_io_cfg_array with 8 pads: load, commit, error, gated shifting,
// same-cycle commit/shift and asynchronous reset.
module tb_grid_io_cfg_array;

  logic       prog_clk;
  logic       pReset;
  wire  [7:0] pad;
  logic [7:0] outpad;
  logic [7:0] inpad;
  logic       ccff_head;
  logic       ccff_en;
  logic       ccff_commit;
  logic       ccff_tail;
  logic       cfg_loaded;
  logic       cfg_err;
  logic       dbg_state;

  logic [7:0] drv_en;
  logic [7:0] drv_val;
  logic [31:0] sr_m;
  logic [31:0] w_cfg;
  logic [31:0] pat;
  int n_cmp;
  int n_fail;

  for (genvar k = 0; k < 8; k++) begin : g_drv
    assign pad[k] = drv_en[k] ? drv_val[k] : 1'bz;
  end

  grid_io_cfg_array #(.NUM_PADS(8)) dut (
    .prog_clk           (prog_clk),
    .pReset             (pReset),
    .gfpga_pad_GPIO_PAD (pad),
    .outpad             (outpad),
    .inpad              (inpad),
    .ccff_head          (ccff_head),
    .ccff_en            (ccff_en),
    .ccff_commit        (ccff_commit),
    .ccff_tail          (ccff_tail),
    .cfg_loaded         (cfg_loaded),
    .cfg_err            (cfg_err),
    .dbg_state          (dbg_state)
  );

  // clock / reset
  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: hold inputs across one rising edge, then sample 1 time unit later
  task automatic cyc(input logic en, input logic head, input logic commit);
    ccff_en     = en;
    ccff_head   = head;
    ccff_commit = commit;
    @(posedge prog_clk);
    #1;
    if (en) sr_m = {sr_m[30:0], head};
    ccff_en     = 1'b0;
    ccff_head   = 1'b0;
    ccff_commit = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    sr_m = '0;
    w_cfg = 32'h0000_C009;
    pat = 32'hA5A5_A5A5;
    ccff_en = 1'b0;
    ccff_head = 1'b0;
    ccff_commit = 1'b0;
    outpad = 8'hFF;
    drv_en = 8'hFF;
    drv_val = 8'h00;
    pReset = 1'b1;
    #3;

    // 1: reset state; pads undriven by DUT so the bench's 0 wins despite outpad=FF
    chk("rst_pad", {24'h0, pad}, 32'h00);
    chk("rst_inpad", {24'h0, inpad}, 32'h00);
    chk("rst_tail", {31'h0, ccff_tail}, 32'h0);
    chk("rst_loaded", {31'h0, cfg_loaded}, 32'h0);
    chk("rst_err", {31'h0, cfg_err}, 32'h0);
    chk("rst_state", {31'h0, dbg_state}, 32'h0);
    repeat (2) @(posedge prog_clk);
    #2;
    pReset = 1'b0;

    // 2: load pad0=1001, pad3=1100, MSB first so sr[i] = w_cfg[i]
    for (int j = 0; j < 31; j++) cyc(1'b1, w_cfg[31-j], 1'b0);
    chk("ld_31_loaded", {31'h0, cfg_loaded}, 32'h0);
    cyc(1'b1, w_cfg[0], 1'b0);
    chk("ld_32_loaded", {31'h0, cfg_loaded}, 32'h1);
    chk("ld_32_state", {31'h0, dbg_state}, 32'h1);
    chk("ld_32_tail", {31'h0, ccff_tail}, 32'h0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("cm_loaded", {31'h0, cfg_loaded}, 32'h0);
    chk("cm_state", {31'h0, dbg_state}, 32'h0);
    chk("cm_err", {31'h0, cfg_err}, 32'h0);
    drv_en = 8'hFE;
    drv_val = 8'h00;
    outpad = 8'hFF;
    #1;
    chk("cm_pad", {24'h0, pad}, 32'h01);
    chk("cm_inpad", {24'h0, inpad}, 32'h09);
    outpad = 8'hFE;
    drv_en = 8'hFE;
    #1;
    chk("cm_pad_lo", {24'h0, pad}, 32'h00);
    chk("cm_inpad_lo", {24'h0, inpad}, 32'h08);
    outpad = 8'hFF;

    // 3: premature commit after 20 shifts
    for (int j = 0; j < 20; j++) cyc(1'b1, 1'b1, 1'b0);
    chk("pre_loaded", {31'h0, cfg_loaded}, 32'h0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("err_set", {31'h0, cfg_err}, 32'h1);
    chk("err_pad", {24'h0, pad}, 32'h01);
    chk("err_inpad", {24'h0, inpad}, 32'h09);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("err_hold", {31'h0, cfg_err}, 32'h1);

    // 4: gated shifting; count is 20, so loaded after the 12th enabled shift
    for (int j = 0; j < 32; j++) begin
      cyc(1'b1, pat[31-j], 1'b0);
      chk("gs_tail_en", {31'h0, ccff_tail}, {31'h0, sr_m[31]});
      chk("gs_loaded_en", {31'h0, cfg_loaded}, {31'h0, (j >= 11)});
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      chk("gs_tail_dis", {31'h0, ccff_tail}, {31'h0, sr_m[31]});
      chk("gs_loaded_dis", {31'h0, cfg_loaded}, {31'h0, (j >= 11)});
    end
    chk("gs_first_bit", {31'h0, ccff_tail}, 32'h1);
    chk("gs_err_hold", {31'h0, cfg_err}, 32'h1);

    // 5: commit with shift in the same cycle; act = A5A5A5A5
    outpad = 8'h14;
    drv_en = 8'hAA;
    drv_val = 8'h82;
    cyc(1'b1, 1'b0, 1'b1);
    chk("cs_pad", {24'h0, pad}, 32'h96);
    chk("cs_inpad", {24'h0, inpad}, 32'h82);
    chk("cs_loaded", {31'h0, cfg_loaded}, 32'h0);
    chk("cs_state", {31'h0, dbg_state}, 32'h0);
    chk("cs_tail", {31'h0, ccff_tail}, 32'h0);
    for (int j = 0; j < 30; j++) cyc(1'b1, 1'b1, 1'b0);
    chk("cs_30_loaded", {31'h0, cfg_loaded}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("cs_31_loaded", {31'h0, cfg_loaded}, 32'h1);

    // 6: asynchronous reset after 16 further shifts
    for (int j = 0; j < 16; j++) cyc(1'b1, 1'b0, 1'b0);
    chk("sat_loaded", {31'h0, cfg_loaded}, 32'h1);
    chk("sat_pad", {24'h0, pad}, 32'h96);
    #2;
    pReset = 1'b1;
    sr_m = '0;
    outpad = 8'hFF;
    drv_en = 8'hFF;
    drv_val = 8'h00;
    #1;
    chk("ar_pad", {24'h0, pad}, 32'h00);
    chk("ar_inpad", {24'h0, inpad}, 32'h00);
    chk("ar_tail", {31'h0, ccff_tail}, 32'h0);
    chk("ar_loaded", {31'h0, cfg_loaded}, 32'h0);
    chk("ar_err", {31'h0, cfg_err}, 32'h0);
    chk("ar_state", {31'h0, dbg_state}, 32'h0);
    #3;
    pReset = 1'b0;
    #2;
    for (int j = 0; j < 31; j++) cyc(1'b1, 1'b1, 1'b0);
    chk("ar_31_loaded", {31'h0, cfg_loaded}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("ar_32_loaded", {31'h0, cfg_loaded}, 32'h1);
    chk("ar_32_tail", {31'h0, ccff_tail}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
